// File: rtl/noc_ni_pkg.sv
// rtl/noc_ni_pkg.sv - shared NoC network-interface flit types and header layout
package noc_ni_pkg;

    typedef logic [1:0] flit_type_t;

    localparam flit_type_t FLIT_BODY   = 2'b00;
    localparam flit_type_t FLIT_HEADER = 2'b01;
    localparam flit_type_t FLIT_TAIL   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } pkt_state_t;

    // Header payload layout, LSB first: dest, then tid, then source id, zero above
    localparam int HDR_DEST_OFS = 0;

    function automatic int hdr_tid_ofs(input int dest_w);
        return HDR_DEST_OFS + dest_w;
    endfunction

    function automatic int hdr_src_ofs(input int dest_w, input int id_w);
        return HDR_DEST_OFS + dest_w + id_w;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - credit counter for router input buffer flow control
module noc_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic issue_i,
    input  logic credit_i,
    output logic ok_o,
    output logic err_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(CREDITS);

    logic [CW-1:0] count;

    // Issue consumes a slot, credit returns one; a credit beyond the buffer depth is a sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= MAX_COUNT;
            err_o <= 1'b0;
        end else begin
            case ({issue_i, credit_i})
                2'b10: count <= count - CW'(1);
                2'b01: begin
                    if (count != MAX_COUNT) begin
                        count <= count + CW'(1);
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ok_o = (count != '0);

endmodule

// File: rtl/axis_noc_packetizer.sv
// rtl/axis_noc_packetizer.sv - AXI4-Stream to NoC flit packetizer, injection side
module axis_noc_packetizer
    import noc_ni_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEST_WIDTH      = 8,
    parameter int ID_WIDTH        = 4,
    parameter int SRC_ID_WIDTH    = 8,
    parameter logic [SRC_ID_WIDTH-1:0] SRC_ID = '0,
    parameter int CREDITS         = 4,
    parameter int FLIT_TYPE_WIDTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [DEST_WIDTH-1:0]                s_axis_tdest,
    input  logic [ID_WIDTH-1:0]                  s_axis_tid,
    input  logic                                 s_axis_tlast,
    output logic [FLIT_TYPE_WIDTH+DATA_WIDTH-1:0] flit_o,
    output logic                                 flit_valid_o,
    input  logic                                 credit_i,
    output logic                                 busy_o,
    output logic                                 credit_err_o
);

    localparam int TID_OFS = hdr_tid_ofs(DEST_WIDTH);
    localparam int SRC_OFS = hdr_src_ofs(DEST_WIDTH, ID_WIDTH);

    pkt_state_t state_q;
    pkt_state_t state_d;
    logic ok;
    logic issue_hdr;
    logic issue_beat;
    logic [DATA_WIDTH-1:0] hdr_payload;

    noc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .issue_i  (issue_hdr | issue_beat),
        .credit_i (credit_i),
        .ok_o     (ok),
        .err_o    (credit_err_o)
    );

    // Header payload from the live first beat; the flit register captures dest/tid so later changes are ignored
    always_comb begin
        hdr_payload = '0;
        hdr_payload[HDR_DEST_OFS +: DEST_WIDTH] = s_axis_tdest;
        hdr_payload[TID_OFS +: ID_WIDTH]        = s_axis_tid;
        hdr_payload[SRC_OFS +: SRC_ID_WIDTH]    = SRC_ID;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: header moves to BODY, the tail handshake returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue_hdr) state_d = ST_BODY;
            ST_BODY: if (issue_beat && s_axis_tlast) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: beats are only accepted in BODY while a credit is available
    always_comb begin
        s_axis_tready = (state_q == ST_BODY) && ok;
        issue_hdr     = (state_q == ST_IDLE) && s_axis_tvalid && ok;
        issue_beat    = (state_q == ST_BODY) && s_axis_tvalid && ok;
        busy_o        = (state_q != ST_IDLE);
    end

    // Flit register: one flit per issue, valid for exactly one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
        end else begin
            flit_valid_o <= issue_hdr | issue_beat;
            if (issue_hdr) begin
                flit_o <= {FLIT_TYPE_WIDTH'(FLIT_HEADER), hdr_payload};
            end else if (issue_beat) begin
                flit_o <= {s_axis_tlast ? FLIT_TYPE_WIDTH'(FLIT_TAIL) : FLIT_TYPE_WIDTH'(FLIT_BODY),
                           s_axis_tdata};
            end
        end
    end

endmodule

// File: tb/tb_axis_noc_packetizer.sv
// tb/tb_axis_noc_packetizer.sv - scoreboard testbench for axis_noc_packetizer
module tb_axis_noc_packetizer;

    localparam int DW = 32;
    localparam int FW = 34;
    localparam logic [7:0] SRC = 8'h11;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [7:0]    s_axis_tdest = '0;
    logic [3:0]    s_axis_tid = '0;
    logic          s_axis_tlast = 1'b0;
    logic [FW-1:0] flit_o;
    logic          flit_valid_o;
    logic          credit_i = 1'b0;
    logic          busy_o;
    logic          credit_err_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int flit_cnt = 0;
    int busy_cnt = 0;
    int flit_cyc[$];
    logic [FW-1:0] sb[$];

    axis_noc_packetizer #(
        .DATA_WIDTH(32), .DEST_WIDTH(8), .ID_WIDTH(4), .SRC_ID_WIDTH(8),
        .SRC_ID(SRC), .CREDITS(4), .FLIT_TYPE_WIDTH(2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tlast  (s_axis_tlast),
        .flit_o        (flit_o),
        .flit_valid_o  (flit_valid_o),
        .credit_i      (credit_i),
        .busy_o        (busy_o),
        .credit_err_o  (credit_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard for every flit the DUT presents
    initial begin
        forever begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (flit_valid_o) begin
                flit_cyc.push_back(cyc);
                flit_cnt++;
                if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
                else check("flit", 64'(flit_o), 64'(sb.pop_front()));
            end
        end
    end

    function automatic logic [FW-1:0] hdr_flit(input logic [7:0] d, input logic [3:0] t);
        return {2'b01, 12'h000, SRC, t, d};
    endfunction

    task automatic credit_pulse();
        credit_i = 1'b1;
        @(posedge clk); #1;
        credit_i = 1'b0;
    endtask

    task automatic wait_flits(input int n);
        int k = 0;
        while (flit_cnt < n && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        if (flit_cnt < n) check("wait_flits_timeout", 64'(flit_cnt), 64'(n));
    endtask

    // Drives one packet; stops early after stop_after beats; optionally holds credit_i high throughout
    task automatic send_pkt(input logic [7:0] d, input logic [3:0] t, input int n,
                            input logic [31:0] base, input int stop_after, input bit hold_credit);
        int k;
        bit hs;
        sb.push_back(hdr_flit(d, t));
        s_axis_tvalid = 1'b1;
        s_axis_tdest  = d;
        s_axis_tid    = t;
        s_axis_tdata  = base;
        s_axis_tlast  = (n == 1);
        if (hold_credit) credit_i = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!busy_o && k < 200);
        if (!busy_o) begin
            check("hdr_timeout", 64'(busy_o), 64'd1);
            s_axis_tvalid = 1'b0;
            credit_i = 1'b0;
            return;
        end
        s_axis_tdest = ~d;
        s_axis_tid   = ~t;
        for (int i = 0; i < n && i < stop_after; i++) begin
            s_axis_tdata = base + 32'(i);
            s_axis_tlast = (i == n - 1);
            k = 0;
            hs = 1'b0;
            while (!hs && k < 200) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    hs = 1'b1;
                    sb.push_back({(i == n - 1) ? 2'b10 : 2'b00, s_axis_tdata});
                end
                @(posedge clk); #1;
                k++;
            end
            if (!hs) begin
                check("hs_timeout", 64'(hs), 64'd1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (hold_credit) credit_i = 1'b0;
    endtask

    // Presents a new packet with no credit available and expects no header
    task automatic expect_stall(input string tag);
        int b = flit_cnt;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_flits"}, 64'(flit_cnt - b), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        int b;
        int bb;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_flit", 64'(flit_o), 64'd0);
        check("rst_valid", 64'(flit_valid_o), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(credit_err_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // 3-beat packet, flits back to back, uses all 4 credits
        b = flit_cnt;
        check("t1_hdr_literal", 64'(hdr_flit(8'h05, 4'h2)), 64'h1_0001_1205);
        send_pkt(8'h05, 4'h2, 3, 32'hA0, 99, 1'b0);
        wait_flits(b + 4);
        check("t1_span", 64'(flit_cyc[b + 3] - flit_cyc[b]), 64'd3);
        @(posedge clk); #1;
        expect_stall("t1_zero_credit");
        repeat (4) credit_pulse();
        check("t1_err_clear", 64'(credit_err_o), 64'd0);

        // 6-beat packet with credit starvation
        b = flit_cnt;
        fork
            send_pkt(8'h21, 4'h3, 6, 32'h100, 99, 1'b0);
            begin
                wait_flits(b + 4);
                check("t2_tready_at_zero", 64'(s_axis_tready), 64'd0);
                repeat (4) @(negedge clk);
                #1;
                check("t2_held4", 64'(flit_cnt - b), 64'd4);
                check("t2_busy", 64'(busy_o), 64'd1);
                @(posedge clk); #1;
                credit_pulse();
                credit_pulse();
                wait_flits(b + 6);
                repeat (4) @(negedge clk);
                #1;
                check("t2_held6", 64'(flit_cnt - b), 64'd6);
                check("t2_tready_stall", 64'(s_axis_tready), 64'd0);
                @(posedge clk); #1;
                credit_pulse();
                wait_flits(b + 7);
            end
        join
        @(posedge clk); #1;
        repeat (4) credit_pulse();

        // Single-beat packet: HEADER then TAIL, busy for one cycle
        b = flit_cnt;
        bb = busy_cnt;
        send_pkt(8'h33, 4'h7, 1, 32'hDEADBEEF, 99, 1'b0);
        wait_flits(b + 2);
        repeat (2) @(posedge clk);
        #1;
        check("t3_busy_cycles", 64'(busy_cnt - bb), 64'd1);
        repeat (2) credit_pulse();

        // Counter at 1 with credit coincident on each issue: no stall over 10 beats
        send_pkt(8'h44, 4'h1, 2, 32'h200, 99, 1'b0);
        b = flit_cnt;
        bb = busy_cnt;
        send_pkt(8'h45, 4'h9, 10, 32'h300, 99, 1'b1);
        wait_flits(b + 11);
        check("t4_span", 64'(flit_cyc[b + 10] - flit_cyc[b]), 64'd10);
        check("t4_busy_cycles", 64'(busy_cnt - bb), 64'd10);
        @(posedge clk); #1;
        repeat (3) credit_pulse();
        check("t4_err_clear", 64'(credit_err_o), 64'd0);

        // Excess credit while full: sticky error, counter does not exceed 4
        credit_pulse();
        check("t5_err_set", 64'(credit_err_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_err_sticky", 64'(credit_err_o), 64'd1);
        b = flit_cnt;
        send_pkt(8'h55, 4'h5, 3, 32'h400, 99, 1'b0);
        wait_flits(b + 4);
        @(posedge clk); #1;
        expect_stall("t5_no_extra_credit");
        repeat (4) credit_pulse();

        // Asynchronous reset after 2 of 5 beats
        send_pkt(8'h66, 4'h6, 5, 32'h500, 2, 1'b0);
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_flit", 64'(flit_o), 64'd0);
        check("t6_valid", 64'(flit_valid_o), 64'd0);
        check("t6_tready", 64'(s_axis_tready), 64'd0);
        check("t6_busy", 64'(busy_o), 64'd0);
        check("t6_err", 64'(credit_err_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        b = flit_cnt;
        send_pkt(8'h77, 4'hA, 1, 32'hCAFE0001, 99, 1'b0);
        send_pkt(8'h78, 4'hB, 1, 32'hCAFE0002, 99, 1'b0);
        wait_flits(b + 4);
        @(posedge clk); #1;
        expect_stall("t6_full_credits");

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
